// File: rtl/axi_stream_slave_skid.sv
// rtl/axi_stream_slave_skid.sv - AXI4-Stream slave with two-entry skid buffer; statistics enabled by AXIS_SKID_STATS_EN
module axi_stream_slave_skid #(
    parameter int byte_width = 4,
    parameter int id_width   = 1,
    parameter int dest_width = 1,
    parameter int user_width = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s_tvalid,
    input  logic [8*byte_width-1:0] s_tdata,
    input  logic [byte_width-1:0]   s_tstrb,
    input  logic [byte_width-1:0]   s_tkeep,
    input  logic                    s_tlast,
    input  logic [id_width-1:0]     s_tid,
    input  logic [dest_width-1:0]   s_tdest,
    input  logic [user_width-1:0]   s_tuser,
    output logic                    s_tready,
    output logic                    m_tvalid,
    output logic [8*byte_width-1:0] m_tdata,
    output logic [byte_width-1:0]   m_tstrb,
    output logic [byte_width-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic [id_width-1:0]     m_tid,
    output logic [dest_width-1:0]   m_tdest,
    output logic [user_width-1:0]   m_tuser,
    input  logic                    m_tready,
    output logic [31:0]             beat_count,
    output logic [31:0]             packet_count,
    output logic [31:0]             byte_count,
    output logic                    strb_err
);

    localparam int pw = 10*byte_width + 1 + id_width + dest_width + user_width;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q, state_d;
    logic [pw-1:0]   s_payload, main_q, skid_q;
    logic            s_tready_q, m_tvalid_q;
    logic            accept, xfer;
    logic            load_main_in, load_main_skid, load_skid;

    assign s_payload = {s_tdata, s_tstrb, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = main_q;
    assign s_tready  = s_tready_q;
    assign m_tvalid  = m_tvalid_q;
    assign accept    = s_tvalid && s_tready_q;
    assign xfer      = m_tvalid_q && m_tready;

    // Next-state and register-load selection for the main/skid pair
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && xfer) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // s_tready is low here, so only the downstream side can move
                if (xfer) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State plus registered handshake outputs derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= EMPTY;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= (state_d != FULL);
            m_tvalid_q <= (state_d != EMPTY);
        end
    end

    // Payload registers; main only changes on a load so it holds under backpressure
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= s_payload;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= s_payload;
            end
        end
    end

`ifdef AXIS_SKID_STATS_EN
    logic [31:0] beat_q, packet_q, byte_q;
    logic        strb_err_q;

    function automatic logic [31:0] popcount(input logic [byte_width-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < byte_width; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Link statistics, updated only on upstream acceptance
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_q     <= '0;
            packet_q   <= '0;
            byte_q     <= '0;
            strb_err_q <= 1'b0;
        end else if (accept) begin
            beat_q <= beat_q + 32'd1;
            byte_q <= byte_q + popcount(s_tkeep);
            if (s_tlast) begin
                packet_q <= packet_q + 32'd1;
            end
            if ((s_tstrb & ~s_tkeep) != '0) begin
                strb_err_q <= 1'b1;
            end
        end
    end

    assign beat_count   = beat_q;
    assign packet_count = packet_q;
    assign byte_count   = byte_q;
    assign strb_err     = strb_err_q;
`else
    assign beat_count   = 32'd0;
    assign packet_count = 32'd0;
    assign byte_count   = 32'd0;
    assign strb_err     = 1'b0;
`endif

endmodule
